// File: rtl/pipe_ctrl_ex.sv
// Purpose : OpenMIPS pipeline controller. Builds the stall vector from per-stage
//           stall requests. Turns MEM-stage exception codes into a flush pulse and
//           a redirect PC. A watchdog breaks stalls that never clear.
// Latency : stall and wdog_timeout are combinational from the inputs. flush,
//           new_pc and last_exc are registered and change one edge after accept.
// Backpressure: there is none upstream. Exception codes and stall requests that
//           arrive while a flush is in progress are dropped.
// Ports   : clk, rst (synchronous, active-high)
//           stallreq_i   - per-stage stall request; bit 0 is unused
//           excepttype_i - MEM-stage exception code; 0 means no exception
//           cp0_epc_i    - return address used for eret (code 0x0E)
//           new_pc       - redirect target; valid while flush=1, otherwise 0
//           flush        - flush all pipeline registers
//           stall        - stall vector; bit 0 is PC, bit i is the register after stage i
//           wdog_timeout - single-cycle pulse in the cycle the watchdog fires
//           last_exc     - code of the most recent accepted event (0x1F = watchdog)
module pipe_ctrl_ex #(
    parameter int            STAGES       = 6,
    parameter int            DW           = 32,
    parameter logic [DW-1:0] INT_VEC      = 'h0000_0020,
    parameter logic [DW-1:0] EXC_VEC      = 'h0000_0040,
    parameter int            FLUSH_CYCLES = 1,
    parameter int            WDOG_LIMIT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [DW-1:0]     cp0_epc_i,
    output logic [DW-1:0]     new_pc,
    output logic              flush,
    output logic [STAGES-1:0] stall,
    output logic              wdog_timeout,
    output logic [31:0]       last_exc
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WCW = $clog2(WDOG_LIMIT);
    localparam logic [FCW-1:0] FC_LOAD   = FCW'(FLUSH_CYCLES - 1);
    localparam logic [WCW-1:0] WD_MAX    = WCW'(WDOG_LIMIT - 1);
    localparam logic [31:0]    WDOG_CODE = 32'h0000_001F;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [DW-1:0]   new_pc_q, new_pc_d;
    logic            flush_q, flush_d;
    logic [31:0]     last_q, last_d;

    logic [STAGES-1:0] req_eff;
    logic [STAGES-1:0] stall_raw;
    logic              exc_pending;
    logic              idle_ok;
    logic              wdog_hit;
    logic [DW-1:0]     exc_target;

    // A stall request at stage k freezes every register upstream of it. The
    // result is a suffix-OR of the requests. An IF request (bit 1) is widened
    // to bit 2, so it holds ID/EX as well, the same way an ID request does.
    // Bit 0 of the request vector has no meaning and is cleared.
    always_comb begin
        req_eff    = stallreq_i;
        req_eff[0] = 1'b0;
        req_eff[2] = stallreq_i[2] | stallreq_i[1];
        stall_raw  = '0;
        stall_raw[STAGES-1] = req_eff[STAGES-1];
        for (int j = STAGES - 2; j >= 0; j--) begin
            stall_raw[j] = stall_raw[j+1] | req_eff[j];
        end
    end

    assign exc_pending = (excepttype_i != 32'd0);
    // Stall is only honoured in IDLE when no exception is pending. Reset and
    // flush both override it.
    assign idle_ok     = !rst && (state_q == IDLE) && !exc_pending;
    assign stall       = idle_ok ? stall_raw : '0;
    assign wdog_hit    = idle_ok && (|stall_raw) && (wcnt_q == WD_MAX);
    assign wdog_timeout = wdog_hit;

    always_comb begin
        exc_target = EXC_VEC;
        case (excepttype_i)
            32'h0000_000F: exc_target = INT_VEC;
            32'h0000_000E: exc_target = cp0_epc_i;
            32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
            32'h0000_0005, 32'h0000_0008, 32'h0000_000A, 32'h0000_000B,
            32'h0000_0017: exc_target = EXC_VEC;
            default:       exc_target = EXC_VEC;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        wcnt_d   = wcnt_q;
        new_pc_d = new_pc_q;
        flush_d  = flush_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (exc_pending || wdog_hit) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    fcnt_d   = FC_LOAD;
                    wcnt_d   = '0;
                    new_pc_d = exc_pending ? exc_target : EXC_VEC;
                    last_d   = exc_pending ? excepttype_i : WDOG_CODE;
                end else if (|stall_raw) begin
                    if (wcnt_q != WD_MAX) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    wcnt_d = '0;
                end
            end
            FLUSH: begin
                // The stall output is 0 during a flush, so the watchdog stays cleared.
                wcnt_d = '0;
                if (fcnt_q == '0) begin
                    state_d  = IDLE;
                    flush_d  = 1'b0;
                    new_pc_d = '0;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            wcnt_q   <= '0;
            new_pc_q <= '0;
            flush_q  <= 1'b0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            wcnt_q   <= wcnt_d;
            new_pc_q <= new_pc_d;
            flush_q  <= flush_d;
            last_q   <= last_d;
        end
    end

    assign new_pc   = new_pc_q;
    assign flush    = flush_q;
    assign last_exc = last_q;

endmodule

// File: tb/tb_pipe_ctrl_ex.sv
// Bench for pipe_ctrl_ex with FLUSH_CYCLES=3 and WDOG_LIMIT=8.
// The driver applies inputs each cycle and pushes the expected outputs into a queue.
// The monitor pops one entry on every falling edge and compares it with the outputs.
module tb_pipe_ctrl_ex;
    localparam int          STAGES  = 6;
    localparam int          DW      = 32;
    localparam int          FC      = 3;
    localparam int          WL      = 8;
    localparam logic [31:0] INT_V   = 32'h0000_0020;
    localparam logic [31:0] EXC_V   = 32'h0000_0040;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [STAGES-1:0] stallreq_i = '0;
    logic [31:0]       excepttype_i = '0;
    logic [DW-1:0]     cp0_epc_i = '0;
    logic [DW-1:0]     new_pc;
    logic              flush;
    logic [STAGES-1:0] stall;
    logic              wdog_timeout;
    logic [31:0]       last_exc;

    always #5 clk = ~clk;

    pipe_ctrl_ex #(
        .STAGES(STAGES), .DW(DW), .INT_VEC(INT_V), .EXC_VEC(EXC_V),
        .FLUSH_CYCLES(FC), .WDOG_LIMIT(WL)
    ) dut (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
        .cp0_epc_i(cp0_epc_i), .new_pc(new_pc), .flush(flush), .stall(stall),
        .wdog_timeout(wdog_timeout), .last_exc(last_exc)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        wd;
        logic [31:0] last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   armed  = 1'b0;

    // Reference model state. m_left is the number of flush cycles still to show.
    // m_run is the number of consecutive stalled cycles seen before this one.
    int          m_left = 0;
    int          m_run  = 0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",        32'(stall),        32'(e.stall));
            chk("flush",        32'(flush),        32'(e.flush));
            chk("new_pc",       new_pc,            e.pc);
            chk("wdog_timeout", 32'(wdog_timeout), 32'(e.wd));
            chk("last_exc",     last_exc,          e.last);
        end
    end

    task automatic model_accept(input logic [31:0] code, input logic [31:0] tgt);
        m_left = FC;
        m_pc   = tgt;
        m_last = code;
        m_run  = 0;
    endtask

    task automatic cyc(input logic r, input logic [5:0] sr, input logic [31:0] ex,
                       input logic [31:0] epc);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        rst = r; stallreq_i = sr; excepttype_i = ex; cp0_epc_i = epc;
        e.flush = (m_left > 0);
        e.pc    = (m_left > 0) ? m_pc : 32'd0;
        e.last  = m_last;
        e.stall = '0;
        e.wd    = 1'b0;
        if (r) begin
            m_left = 0; m_pc = '0; m_last = '0; m_run = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_run = 0;
        end else if (ex != 0) begin
            model_accept(ex, (ex == 32'h0F) ? INT_V : (ex == 32'h0E) ? epc : EXC_V);
        end else begin
            k = 0;
            for (int i = 1; i < 6; i++) if (sr[i]) k = i;
            if (k == 0) begin
                m_run = 0;
            end else begin
                if (k == 1) k = 2;
                e.stall = 6'((1 << (k + 1)) - 1);
                if (m_run == WL - 1) begin
                    e.wd = 1'b1;
                    model_accept(32'h1F, EXC_V);
                end else begin
                    m_run++;
                end
            end
        end
        if (armed) q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'b0, 32'd0, 32'd0);
    endtask

    logic [5:0]  stall_pats [6] = '{6'b010000, 6'b001000, 6'b000100,
                                    6'b000010, 6'b010100, 6'b000000};
    logic [31:0] codes [14] = '{32'h0F, 32'h0E, 32'h01, 32'h02, 32'h03, 32'h04, 32'h05,
                                32'h08, 32'h0A, 32'h0B, 32'h17, 32'h13, 32'h1F, 32'h07};

    initial begin
        logic [5:0]  sr;
        logic [31:0] ex;
        logic        r;

        // The first reset edges leave the outputs unknown, so nothing is checked yet.
        cyc(1'b1, 6'b0, 32'd0, 32'd0);
        cyc(1'b1, 6'b0, 32'd0, 32'd0);
        armed = 1'b1;
        // rst must force stall to 0 even while a stall is requested.
        cyc(1'b1, 6'b010000, 32'd0, 32'd0);
        idle(1);

        // Stall encodings.
        foreach (stall_pats[i]) cyc(1'b0, stall_pats[i], 32'd0, 32'd0);

        // Interrupt while a stall is requested.
        cyc(1'b0, 6'b010000, 32'h0F, 32'd0);
        idle(3);

        // eret. A second code that arrives in flush cycle 2 must be ignored.
        cyc(1'b0, 6'b0, 32'h0E, 32'h8000_1234);
        cyc(1'b0, 6'b0, 32'd0, 32'd0);
        cyc(1'b0, 6'b0, 32'h08, 32'd0);
        idle(3);

        // An unknown code and a listed code both redirect to EXC_VEC.
        cyc(1'b0, 6'b0, 32'h13, 32'd0);
        idle(4);
        cyc(1'b0, 6'b0, 32'h0A, 32'd0);
        idle(4);

        // The watchdog fires on the 8th consecutive stalled cycle.
        for (int i = 0; i < 10; i++) cyc(1'b0, 6'b001000, 32'd0, 32'd0);
        idle(4);
        // Dropping the request at cycle 5 restarts the count.
        for (int i = 0; i < 5; i++) cyc(1'b0, 6'b001000, 32'd0, 32'd0);
        idle(1);
        for (int i = 0; i < 9; i++) cyc(1'b0, 6'b001000, 32'd0, 32'd0);
        idle(5);

        // Reset during flush cycle 2, then an exception one cycle after reset ends.
        cyc(1'b0, 6'b0, 32'h04, 32'd0);
        cyc(1'b0, 6'b0, 32'd0, 32'd0);
        cyc(1'b1, 6'b0, 32'd0, 32'd0);
        cyc(1'b0, 6'b0, 32'h0F, 32'd0);
        idle(5);

        // Randomised traffic. Stall requests are held for several cycles so the
        // watchdog fires now and then.
        sr = '0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) sr = 6'($urandom);
            ex = 32'd0;
            if ($urandom_range(0, 14) == 0) begin
                if ($urandom_range(0, 4) == 0) ex = $urandom | 32'h100;
                else ex = codes[$urandom_range(0, 13)];
            end
            cyc(r, sr, ex, $urandom);
        end

        idle(1);
        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_ex.md
Name: pipe_ctrl_ex

Overview:
Parametrised pipeline controller for the OpenMIPS core. It turns per-stage stall requests into a stall vector and turns MEM-stage exception codes into a registered flush pulse plus a redirect PC. Flush length is configurable. A stall watchdog forces recovery from a hung stall. The block sits beside the pipeline registers and drives their stall/flush inputs and the PC mux.

Parameters:
STAGES, 6, number of stall-vector bits; bit 0 = PC register, bit i = pipeline register after stage i
DW, 32, data/address width
INT_VEC, 32'h00000020, redirect target for interrupt (code 0x0F)
EXC_VEC, 32'h00000040, redirect target for all other synchronous exceptions and for watchdog timeout
FLUSH_CYCLES, 1, cycles flush stays high per event (>=1)
WDOG_LIMIT, 1024, consecutive stalled cycles that trigger a timeout (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
stallreq_i  in  STAGES  bit i = stage i requests stall; bit 0 ignored
excepttype_i  in  32  exception code from MEM; 0 = none
cp0_epc_i  in  DW  EPC for eret
new_pc  out  DW  redirect PC, valid while flush=1
flush  out  1  flush all pipeline registers
stall  out  STAGES  stall vector
wdog_timeout  out  1  one-cycle pulse on watchdog expiry
last_exc  out  32  code of most recent accepted event (0x1F = watchdog)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; new_pc=0, flush=0, wdog_timeout=0, last_exc=0; flush counter=0; watchdog counter=0. Stall is forced to 0 while rst=1.
- States: IDLE, FLUSH.
- Stall, combinational:
  - In IDLE with excepttype_i==0: let k = highest index i>=1 with stallreq_i[i]=1. Then stall[k:0]=1 and all higher bits = 0.
  - Exception: if k==1, stall[2:0]=1. An IF request freezes the PC, IF/ID and ID/EX, same as an ID request.
  - No request gives stall=0.
  - In FLUSH, or when excepttype_i!=0: stall=0.
- Exception accept: in IDLE at a posedge with excepttype_i!=0, the event is accepted. Target decode:
  - 0x0F → INT_VEC.
  - 0x0E (eret) → cp0_epc_i sampled that cycle.
  - 0x01–0x05, 0x08, 0x0A, 0x0B, 0x17 → EXC_VEC.
  - Any other nonzero code → EXC_VEC.
- Effects of accept at edge N:
  - new_pc ← target, last_exc ← code, flush ← 1, state ← FLUSH, flush counter ← FLUSH_CYCLES-1, watchdog counter ← 0.
  - flush is therefore high in cycles N+1 … N+FLUSH_CYCLES.
- In FLUSH:
  - counter==0 → next edge sets flush←0, new_pc←0, state←IDLE.
  - Otherwise the counter decrements.
  - excepttype_i and stallreq_i are ignored.
  - new_pc holds its value throughout.
- Watchdog:
  - In IDLE, the counter increments each cycle stall!=0, saturating at WDOG_LIMIT-1.
  - It clears on any cycle with stall==0 or on accept.
  - When the counter equals WDOG_LIMIT-1, stall is still !=0 and excepttype_i==0, the edge performs an accept with target EXC_VEC and code 0x1F, and wdog_timeout=1 for that single cycle.
- Priority at the same edge: rst > exception > watchdog > stall.
- rst asserted mid-FLUSH aborts the flush: all outputs return to reset values at that edge.
- new_pc is 0 whenever flush=0.

Test Plan:
- Stall encoding: stallreq_i=6'b010000 → stall=6'b011111. Then 6'b001000 → 6'b001111; 6'b000100 → 6'b000111; 6'b000010 → 6'b000111; 6'b010100 → 6'b011111; 0 → 0.
- Interrupt: excepttype_i=0x0F for one cycle with stallreq_i=6'b010000 → stall=0 that cycle; next cycle flush=1, new_pc=0x20, last_exc=0x0F; the following cycle flush=0, new_pc=0.
- eret with FLUSH_CYCLES=3: cp0_epc_i=0x80001234, code 0x0E → flush=1 for exactly 3 cycles with new_pc=0x80001234. A second code 0x08 presented in flush cycle 2 is ignored, and last_exc stays 0x0E.
- Unknown code 0x13 → flush one cycle, new_pc=0x40. Code 0x0A → new_pc=0x40.
- Watchdog with WDOG_LIMIT=8: hold stallreq_i=6'b001000 → stall=6'b001111 for 7 cycles. On the 8th cycle wdog_timeout=1; next cycle flush=1, new_pc=0x40, last_exc=0x1F. Dropping the request at cycle 5 and reasserting it restarts the count, with no timeout before 8 further cycles.
- Reset mid-flush with FLUSH_CYCLES=4: rst=1 in flush cycle 2 → next cycle flush=0, new_pc=0, last_exc=0, state IDLE. An exception presented one cycle after rst deasserts is accepted normally.
